// File: rtl/acc_layer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_layer_sched : per-layer sequencer between PE array, psum accumulator    |
// |                   and output buffer.                          Revision 1.0 |
// +----------------------------------------------------------------------------+
module acc_layer_sched #(
   parameter int ADDR_W = 16,
   parameter int PSUM_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [9:0]        cfg_ofmap_size_i,
   input  logic [5:0]        cfg_ifmap_ch_i,
   input  logic [5:0]        cfg_ofmap_ch_i,
   output logic              pe_start_o,
   input  logic [PSUM_W-1:0] pe_psum_i,
   input  logic              pe_pvalid_i,
   output logic              pe_pready_o,
   output logic [PSUM_W-1:0] acc_psum_o,
   output logic              acc_pvalid_o,
   input  logic              acc_pready_i,
   output logic [9:0]        acc_ofmap_size_o,
   output logic [5:0]        acc_ifmap_ch_o,
   input  logic              acc_conv_valid_i,
   input  logic [PSUM_W-1:0] acc_conv_result_i,
   output logic              obuf_wren_o,
   output logic [ADDR_W-1:0] obuf_addr_o,
   output logic [PSUM_W-1:0] obuf_data_o,
   output logic              busy_o,
   output logic              layer_done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              r_state;
   logic [9:0]          r_ofmap_size;
   logic [5:0]          r_ifmap_ch;
   logic [5:0]          r_ofmap_ch;
   logic [15:0]         r_ps_last;
   logic [15:0]         r_ps_cnt;
   logic [9:0]          r_px_cnt;
   logic [5:0]          r_oc_cnt;
   logic [ADDR_W-1:0]   r_out_addr;
   logic                r_wren;
   logic [ADDR_W-1:0]   r_addr;
   logic [PSUM_W-1:0]   r_data;
   logic                r_err;

   logic                w_stream;
   logic                w_hs;
   logic                w_result;
   logic                w_accept;
   logic [16:0]         w_ps_total;

   assign w_stream = (r_state == S_STREAM);
   assign w_hs     = w_stream & pe_pvalid_i & acc_pready_i;
   assign w_result = (r_state == S_DRAIN) & acc_conv_valid_i;
   assign w_accept = (r_state == S_IDLE) & cfg_valid_i;

   // Psums per output channel, computed once at accept so the stream
   // compare stays a plain equality.  17 bits holds 1024*64 exactly.
   assign w_ps_total = (17'(cfg_ofmap_size_i) + 17'd1) * (17'(cfg_ifmap_ch_i) + 17'd1);

   assign cfg_ready_o      = (r_state == S_IDLE);
   assign busy_o           = (r_state != S_IDLE);
   assign pe_start_o       = (r_state == S_START);
   assign layer_done_o     = (r_state == S_DONE);

   assign acc_psum_o       = w_stream ? pe_psum_i : '0;
   assign acc_pvalid_o     = w_stream & pe_pvalid_i;
   assign pe_pready_o      = w_stream & acc_pready_i;

   assign acc_ofmap_size_o = r_ofmap_size;
   assign acc_ifmap_ch_o   = r_ifmap_ch;
   assign obuf_wren_o      = r_wren;
   assign obuf_addr_o      = r_addr;
   assign obuf_data_o      = r_data;
   assign err_o            = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ofmap_size <= '0;
         r_ifmap_ch   <= '0;
         r_ofmap_ch   <= '0;
         r_ps_last    <= '0;
         r_ps_cnt     <= '0;
         r_px_cnt     <= '0;
         r_oc_cnt     <= '0;
         r_out_addr   <= '0;
         r_wren       <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_err        <= 1'b0;
      end else begin
         // Results are only legal while draining; anything else is flagged.
         r_wren <= w_result;
         if (w_result) begin
            r_addr <= r_out_addr;
            r_data <= acc_conv_result_i;
         end
         if (acc_conv_valid_i && (r_state != S_DRAIN)) begin
            r_err <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ofmap_size <= cfg_ofmap_size_i;
                  r_ifmap_ch   <= cfg_ifmap_ch_i;
                  r_ofmap_ch   <= cfg_ofmap_ch_i;
                  r_ps_last    <= 16'(w_ps_total - 17'd1);
                  r_ps_cnt     <= '0;
                  r_px_cnt     <= '0;
                  r_oc_cnt     <= '0;
                  r_out_addr   <= '0;
                  r_state      <= S_START;
               end
            end
            S_START: begin
               r_state <= S_STREAM;
            end
            S_STREAM: begin
               if (w_hs) begin
                  r_ps_cnt <= r_ps_cnt + 16'd1;
                  if (r_ps_cnt == r_ps_last) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (acc_conv_valid_i) begin
                  // Running address replaces oc*(size+1)+px; wraps naturally.
                  r_out_addr <= r_out_addr + ADDR_W'(1);
                  r_px_cnt   <= r_px_cnt + 10'd1;
                  if (r_px_cnt == r_ofmap_size) begin
                     if (r_oc_cnt == r_ofmap_ch) begin
                        r_state <= S_DONE;
                     end else begin
                        r_oc_cnt <= r_oc_cnt + 6'd1;
                        r_ps_cnt <= '0;
                        r_px_cnt <= '0;
                        r_state  <= S_START;
                     end
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_acc_layer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acc_layer_sched : directed/random bench for acc_layer_sched.             |
// |                                                               Revision 1.0 |
// +----------------------------------------------------------------------------+
module tb_acc_layer_sched;

   localparam int ADDR_W = 16;
   localparam int PSUM_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_valid_i = 1'b0;
   logic              cfg_ready_o;
   logic [9:0]        cfg_ofmap_size_i = '0;
   logic [5:0]        cfg_ifmap_ch_i = '0;
   logic [5:0]        cfg_ofmap_ch_i = '0;
   logic              pe_start_o;
   logic [PSUM_W-1:0] pe_psum_i = '0;
   logic              pe_pvalid_i = 1'b0;
   logic              pe_pready_o;
   logic [PSUM_W-1:0] acc_psum_o;
   logic              acc_pvalid_o;
   logic              acc_pready_i = 1'b0;
   logic [9:0]        acc_ofmap_size_o;
   logic [5:0]        acc_ifmap_ch_o;
   logic              acc_conv_valid_i = 1'b0;
   logic [PSUM_W-1:0] acc_conv_result_i = '0;
   logic              obuf_wren_o;
   logic [ADDR_W-1:0] obuf_addr_o;
   logic [PSUM_W-1:0] obuf_data_o;
   logic              busy_o;
   logic              layer_done_o;
   logic              err_o;

   acc_layer_sched #(.ADDR_W(ADDR_W), .PSUM_W(PSUM_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_valid_i       (cfg_valid_i),
      .cfg_ready_o       (cfg_ready_o),
      .cfg_ofmap_size_i  (cfg_ofmap_size_i),
      .cfg_ifmap_ch_i    (cfg_ifmap_ch_i),
      .cfg_ofmap_ch_i    (cfg_ofmap_ch_i),
      .pe_start_o        (pe_start_o),
      .pe_psum_i         (pe_psum_i),
      .pe_pvalid_i       (pe_pvalid_i),
      .pe_pready_o       (pe_pready_o),
      .acc_psum_o        (acc_psum_o),
      .acc_pvalid_o      (acc_pvalid_o),
      .acc_pready_i      (acc_pready_i),
      .acc_ofmap_size_o  (acc_ofmap_size_o),
      .acc_ifmap_ch_o    (acc_ifmap_ch_o),
      .acc_conv_valid_i  (acc_conv_valid_i),
      .acc_conv_result_i (acc_conv_result_i),
      .obuf_wren_o       (obuf_wren_o),
      .obuf_addr_o       (obuf_addr_o),
      .obuf_data_o       (obuf_data_o),
      .busy_o            (busy_o),
      .layer_done_o      (layer_done_o),
      .err_o             (err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;
   int start_cnt = 0;
   int wr_cnt = 0;
   logic exp_err = 1'b0;

   // Event counters seen from the outside of the DUT.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pe_start_o) start_cnt++;
         if (pe_pvalid_i && pe_pready_o) hs_cnt++;
         if (obuf_wren_o) wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Plays PE array and accumulator for one layer; pr_mode 0=always ready,
   // 1=toggle every cycle, 2=random.  Expected addresses follow
   // oc*(pixels per channel)+px.
   task automatic run_layer(input int size, input int ifch, input int ofch, input int pr_mode,
                            input bit busy_cfg, input bit fixed, input logic [7:0] fdata);
      int n;
      int hs0;
      int st0;
      int wr0;
      int k;
      int cyc;
      int gap;
      logic [7:0] cur_psum;
      logic [7:0] d;
      n = (size + 1) * (ifch + 1);
      @(posedge clk); #1;
      cfg_valid_i      = 1'b1;
      cfg_ofmap_size_i = 10'(size);
      cfg_ifmap_ch_i   = 6'(ifch);
      cfg_ofmap_ch_i   = 6'(ofch);
      @(negedge clk);
      check("cfg_ready_idle", 32'(cfg_ready_o), 32'd1);
      hs0 = hs_cnt; st0 = start_cnt; wr0 = wr_cnt;
      @(posedge clk); #1;
      cfg_valid_i = busy_cfg;
      if (busy_cfg) begin
         cfg_ofmap_size_i = 10'($urandom);
         cfg_ifmap_ch_i   = 6'($urandom);
         cfg_ofmap_ch_i   = 6'($urandom);
      end
      for (int oc = 0; oc <= ofch; oc++) begin
         if (oc == 0) begin
            @(negedge clk);
            check("pe_start_first", 32'(pe_start_o), 32'd1);
         end
         check("acc_size_cfg", 32'(acc_ofmap_size_o), 32'(size));
         check("acc_ifch_cfg", 32'(acc_ifmap_ch_o), 32'(ifch));
         check("busy_in_layer", 32'(busy_o), 32'd1);
         @(posedge clk); #1;
         k = 0; cyc = 0;
         cur_psum = fixed ? fdata : 8'($urandom);
         while (k < n && cyc < 4000) begin
            pe_pvalid_i = 1'b1;
            pe_psum_i   = cur_psum;
            case (pr_mode)
               0:       acc_pready_i = 1'b1;
               1:       acc_pready_i = ((cyc % 2) == 1);
               default: acc_pready_i = 1'($urandom_range(0, 1));
            endcase
            if (busy_cfg) begin
               cfg_ofmap_size_i = 10'($urandom);
               cfg_ifmap_ch_i   = 6'($urandom);
            end
            @(negedge clk);
            check("pready_mirror", 32'(pe_pready_o), 32'(acc_pready_i));
            check("pvalid_pass", 32'(acc_pvalid_o), 32'd1);
            check("psum_pass", 32'(acc_psum_o), 32'(cur_psum));
            if (acc_pready_i) begin
               k++;
               cur_psum = fixed ? fdata : 8'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
         end
         check("stream_count", 32'(k), 32'(n));
         pe_pvalid_i  = 1'b0;
         acc_pready_i = 1'b1;
         cfg_valid_i  = 1'b0;
         @(negedge clk);
         check("pready_off_drain", 32'(pe_pready_o), 32'd0);
         check("psum_zero_drain", 32'(acc_psum_o), 32'd0);
         acc_pready_i = 1'b0;
         for (int px = 0; px <= size; px++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
               repeat (gap) @(posedge clk);
               #1;
            end
            d = fixed ? fdata : 8'($urandom);
            acc_conv_result_i = d;
            acc_conv_valid_i  = 1'b1;
            @(posedge clk); #1;
            acc_conv_valid_i  = 1'b0;
            acc_conv_result_i = 8'($urandom);
            @(negedge clk);
            check("obuf_wren", 32'(obuf_wren_o), 32'd1);
            check("obuf_addr", 32'(obuf_addr_o), 32'((oc * (size + 1) + px) % 65536));
            check("obuf_data", 32'(obuf_data_o), 32'(d));
            if (px == size) begin
               if (oc == ofch) check("layer_done", 32'(layer_done_o), 32'd1);
               else            check("next_start", 32'(pe_start_o), 32'd1);
            end else begin
               check("no_early_done", 32'(layer_done_o), 32'd0);
            end
         end
      end
      @(negedge clk);
      check("busy_after_done", 32'(busy_o), 32'd0);
      check("done_one_cycle", 32'(layer_done_o), 32'd0);
      check("err_state", 32'(err_o), 32'(exp_err));
      @(negedge clk);
      check("still_idle", 32'(busy_o), 32'd0);
      check("handshakes", 32'(hs_cnt - hs0), 32'(n * (ofch + 1)));
      check("start_pulses", 32'(start_cnt - st0), 32'(ofch + 1));
      check("writes", 32'(wr_cnt - wr0), 32'((size + 1) * (ofch + 1)));
   endtask

   int wr_snap;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_wren", 32'(obuf_wren_o), 32'd0);
      check("rst_start", 32'(pe_start_o), 32'd0);
      rst_n = 1'b1;

      run_layer(3, 1, 0, 0, 1'b0, 1'b0, 8'h00);
      run_layer(1, 0, 2, 0, 1'b0, 1'b0, 8'h00);
      run_layer(4, 2, 1, 1, 1'b0, 1'b0, 8'h00);

      // Stray result while idle.
      @(posedge clk); #1;
      acc_conv_valid_i  = 1'b1;
      acc_conv_result_i = 8'h55;
      wr_snap = wr_cnt;
      @(posedge clk); #1;
      acc_conv_valid_i = 1'b0;
      @(negedge clk);
      check("idle_result_nowrite", 32'(obuf_wren_o), 32'd0);
      check("idle_result_err", 32'(err_o), 32'd1);
      check("idle_result_busy", 32'(busy_o), 32'd0);
      exp_err = 1'b1;
      @(negedge clk);
      check("idle_result_wrcnt", 32'(wr_cnt - wr_snap), 32'd0);

      run_layer(2, 1, 1, 2, 1'b1, 1'b0, 8'h00);

      // Reset in the middle of streaming.
      @(posedge clk); #1;
      cfg_valid_i = 1'b1; cfg_ofmap_size_i = 10'd5; cfg_ifmap_ch_i = 6'd2; cfg_ofmap_ch_i = 6'd1;
      @(posedge clk); #1;
      cfg_valid_i = 1'b0;
      pe_pvalid_i = 1'b1; acc_pready_i = 1'b1; pe_psum_i = 8'hA5;
      wr_snap = wr_cnt;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_cfg_ready", 32'(cfg_ready_o), 32'd1);
      check("arst_pready", 32'(pe_pready_o), 32'd0);
      check("arst_pvalid", 32'(acc_pvalid_o), 32'd0);
      check("arst_psum", 32'(acc_psum_o), 32'd0);
      check("arst_wren", 32'(obuf_wren_o), 32'd0);
      check("arst_addr", 32'(obuf_addr_o), 32'd0);
      check("arst_size", 32'(acc_ofmap_size_o), 32'd0);
      check("arst_ifch", 32'(acc_ifmap_ch_o), 32'd0);
      check("arst_err", 32'(err_o), 32'd0);
      exp_err = 1'b0;
      pe_pvalid_i = 1'b0; acc_pready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("arst_no_stale_write", 32'(wr_cnt - wr_snap), 32'd0);

      run_layer(0, 0, 0, 0, 1'b0, 1'b1, 8'h7F);

      for (int i = 0; i < 3; i++) begin
         run_layer($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop so the bench cannot hang on a broken design.
   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/acc_layer_sched.md
Name: acc_layer_sched

Overview:
- Layer-level sequencer for the psum accumulator.
- Accepts one layer configuration and issues a start pulse to the PE array once per output channel.
- Forwards the PE psum stream to the accumulator over valid/ready, drives the accumulator's size/channel configuration, and writes the saturated conv results into the output buffer at linear addresses.
- Sits between the PE array, the accumulator and the output SRAM.

Parameters:
- ADDR_W, 16, output buffer address width.
- PSUM_W, 8, psum and result data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid_i  in  1  layer config valid
- cfg_ready_o  out  1  config accepted (high in IDLE only)
- cfg_ofmap_size_i  in  10  last pixel index per channel (pixel count minus 1)
- cfg_ifmap_ch_i  in  6  last input-channel index (count minus 1)
- cfg_ofmap_ch_i  in  6  last output-channel index (count minus 1)
- pe_start_o  out  1  one-cycle pulse, PE array starts one output channel
- pe_psum_i  in  PSUM_W  psum from PE array
- pe_pvalid_i  in  1  psum valid
- pe_pready_o  out  1  psum ready to PE array
- acc_psum_o  out  PSUM_W  psum to accumulator
- acc_pvalid_o  out  1  psum valid to accumulator
- acc_pready_i  in  1  accumulator ready
- acc_ofmap_size_o  out  10  accumulator ofmap_size
- acc_ifmap_ch_o  out  6  accumulator ifmap_ch
- acc_conv_valid_i  in  1  accumulator result valid
- acc_conv_result_i  in  PSUM_W  saturated result
- obuf_wren_o  out  1  output buffer write enable
- obuf_addr_o  out  ADDR_W  output buffer address
- obuf_data_o  out  PSUM_W  output buffer data
- busy_o  out  1  high outside IDLE
- layer_done_o  out  1  one-cycle pulse at layer end
- err_o  out  1  sticky: conv_valid seen outside DRAIN

Behaviour:
- Reset (asynchronous, any time including mid-layer):
  - state returns to IDLE.
  - All counters, config registers and registered outputs clear to 0.
  - err_o clears to 0.
- Config registers are latched on cfg_valid_i && cfg_ready_o. acc_ofmap_size_o and acc_ifmap_ch_o are driven from these registers and stay stable until the next accept.
- Counters:
  - ps_cnt: psum handshakes in the current output channel.
  - px_cnt: results received in the current output channel.
  - oc_cnt: current output channel index.
  - out_addr: running buffer address, cleared on config accept.
- IDLE:
  - cfg_ready_o=1, busy_o=0.
  - On accept: clear counters, go to START.
- START:
  - pe_start_o=1 for exactly this cycle; go to STREAM.
- STREAM (combinational passthrough):
  - acc_psum_o=pe_psum_i, acc_pvalid_o=pe_pvalid_i, pe_pready_o=acc_pready_i.
  - A handshake is pe_pvalid_i && acc_pready_i; ps_cnt increments on each.
  - On the handshake with ps_cnt == (ofmap_size+1)*(ifmap_ch+1)-1, go to DRAIN.
  - Outside STREAM: acc_pvalid_o=0, pe_pready_o=0, acc_psum_o=0.
- DRAIN:
  - Each acc_conv_valid_i registers one write on the next cycle: obuf_wren_o=1, obuf_addr_o=out_addr, obuf_data_o=acc_conv_result_i.
  - out_addr and px_cnt increment on each result.
  - On the result with px_cnt==ofmap_size:
    - if oc_cnt==ofmap_ch, go to DONE;
    - else increment oc_cnt, clear ps_cnt and px_cnt, go to START.
- DONE:
  - layer_done_o=1 for one cycle; this coincides with the final obuf write.
  - Go to IDLE.
- Latency:
  - obuf write follows conv_valid by exactly 1 cycle.
  - pe_start_o for the next output channel follows the final result of the previous one by 1 cycle.
- Addressing: address = oc*(ofmap_size+1)+px, produced by the running counter with no multiplier. It wraps modulo 2^ADDR_W silently.
- acc_conv_valid_i outside DRAIN:
  - No obuf write.
  - No counter change.
  - err_o set; held until reset.
- Minimum config (all fields 0): one psum, one result, one write at address 0, done.
- cfg_valid_i while busy is ignored and not queued.
- pe_pvalid_i while acc_pready_i=0 is stalled; data must be held by the PE array.

Test Plan:
- ofmap_size=3, ifmap_ch=1, ofmap_ch=0; 8 psums; accumulator returns 4 results -> exactly 8 handshakes, writes at addresses 0..3 with matching data, layer_done_o in the cycle of the address-3 write, 1 pe_start_o pulse.
- ofmap_size=1, ifmap_ch=0, ofmap_ch=2 -> 3 pe_start_o pulses, writes at addresses 0..5, busy_o low the cycle after done.
- acc_pready_i toggled every other cycle during STREAM -> ps_cnt counts only true handshakes; pe_pready_o mirrors acc_pready_i.
- rst_n asserted mid-STREAM, then a new config -> all outputs 0 immediately, restart from address 0, no stale writes.
- acc_conv_valid_i pulsed in IDLE, and cfg_valid_i pulsed while busy -> no write, err_o=1 sticky, config unchanged.
- All-zero config -> 1 psum, 1 write to address 0, data 0x7F passed through intact.
